// File: rtl/status_reg.sv
// status_reg: 6502 processor status (P) register.
// Holds N, V, D, I, Z, C; derives ALU flags from the ALU result,
// services PHP/PLP/RTI/BRK and evaluates conditional-branch tests.
module status_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] alu_a,
    input  logic [7:0] alu_b,
    input  logic [7:0] alu_f,
    input  logic       alu_co,
    input  logic       alu_sub,
    input  logic       en_nz,
    input  logic       en_c,
    input  logic       en_v,
    input  logic       bit_mode,
    input  logic [2:0] flag_op,
    input  logic       ld_p,
    input  logic [7:0] db,
    input  logic       irq_take,
    input  logic       brk_in,
    input  logic [2:0] cond,
    output logic [7:0] p_push,
    output logic       c_out,
    output logic       d_out,
    output logic       i_out,
    output logic       br_taken
);

    // Explicit flag set/clear instruction codes
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_CLC  = 3'd1;
    localparam logic [2:0] OP_SEC  = 3'd2;
    localparam logic [2:0] OP_CLI  = 3'd3;
    localparam logic [2:0] OP_SEI  = 3'd4;
    localparam logic [2:0] OP_CLD  = 3'd5;
    localparam logic [2:0] OP_SED  = 3'd6;
    localparam logic [2:0] OP_CLV  = 3'd7;

    // Stored flags
    logic n_reg, v_reg, d_reg, i_reg, z_reg, c_reg;
    logic n_next, v_next, d_next, i_next, z_next, c_next;

    // ALU-derived flag candidates
    logic n_alu, v_alu, z_alu;
    logic b7_eff;

    // Only the sign bits of the operands matter for overflow detection
    logic unused_operand_bits;
    assign unused_operand_bits = ^{alu_a[6:0], alu_b[5:0]};

    // Derive N/Z/V candidates from the ALU operands and result
    always_comb begin
        z_alu  = (alu_f == 8'h00);
        b7_eff = alu_b[7] ^ alu_sub;
        if (bit_mode) begin
            n_alu = alu_b[7];
            v_alu = alu_b[6];
        end else begin
            n_alu = alu_f[7];
            // Signed overflow: operands agree in sign, result disagrees
            v_alu = (alu_a[7] == b7_eff) && (alu_f[7] != alu_a[7]);
        end
    end

    // Next N and Z: stack load wins, otherwise ALU update when enabled
    always_comb begin
        n_next = n_reg;
        z_next = z_reg;
        if (ld_p) begin
            n_next = db[7];
            z_next = db[1];
        end else if (en_nz) begin
            n_next = n_alu;
            z_next = z_alu;
        end
    end

    // Next C: stack load, then CLC/SEC, then ALU carry-out
    always_comb begin
        c_next = c_reg;
        if (ld_p) begin
            c_next = db[0];
        end else if (flag_op == OP_CLC) begin
            c_next = 1'b0;
        end else if (flag_op == OP_SEC) begin
            c_next = 1'b1;
        end else if (en_c) begin
            c_next = alu_co;
        end
    end

    // Next V: stack load, then CLV, then ALU overflow / BIT bit 6
    always_comb begin
        v_next = v_reg;
        if (ld_p) begin
            v_next = db[6];
        end else if (flag_op == OP_CLV) begin
            v_next = 1'b0;
        end else if (en_v) begin
            v_next = v_alu;
        end
    end

    // Next D: stack load, then CLD/SED
    always_comb begin
        d_next = d_reg;
        if (ld_p) begin
            d_next = db[3];
        end else if (flag_op == OP_CLD) begin
            d_next = 1'b0;
        end else if (flag_op == OP_SED) begin
            d_next = 1'b1;
        end
    end

    // Next I: interrupt entry always masks, even over a stack load or CLI
    always_comb begin
        i_next = i_reg;
        if (irq_take) begin
            i_next = 1'b1;
        end else if (ld_p) begin
            i_next = db[2];
        end else if (flag_op == OP_CLI) begin
            i_next = 1'b0;
        end else if (flag_op == OP_SEI) begin
            i_next = 1'b1;
        end
    end

    // Flag storage; reset leaves interrupts masked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_reg <= 1'b0;
            v_reg <= 1'b0;
            d_reg <= 1'b0;
            i_reg <= 1'b1;
            z_reg <= 1'b0;
            c_reg <= 1'b0;
        end else begin
            n_reg <= n_next;
            v_reg <= v_next;
            d_reg <= d_next;
            i_reg <= i_next;
            z_reg <= z_next;
            c_reg <= c_next;
        end
    end

    // Branch test: cond[2:1] picks the flag, cond[0] picks the polarity
    always_comb begin
        logic sel_flag;
        sel_flag = n_reg;
        case (cond[2:1])
            2'b00:   sel_flag = n_reg;
            2'b01:   sel_flag = v_reg;
            2'b10:   sel_flag = c_reg;
            default: sel_flag = z_reg;
        endcase
        br_taken = ~(sel_flag ^ cond[0]);
    end

    // Stack image: bit 5 reads as 1, bit 4 reflects BRK vs hardware IRQ
    assign p_push = {n_reg, v_reg, 1'b1, brk_in, d_reg, i_reg, z_reg, c_reg};
    assign c_out  = c_reg;
    assign d_out  = d_reg;
    assign i_out  = i_reg;

endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: randomized and directed check of status_reg against
// a P-register image model.
module tb_status_reg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] alu_a, alu_b, alu_f, db;
    logic       alu_co, alu_sub, en_nz, en_c, en_v, bit_mode;
    logic [2:0] flag_op, cond;
    logic       ld_p, irq_take, brk_in;
    logic [7:0] p_push;
    logic       c_out, d_out, i_out, br_taken;

    int checks = 0;
    int errors = 0;

    // Model state: the architectural P byte (bits 5 and 4 kept at 0)
    logic [7:0] mp;
    logic [7:0] nx;
    logic [7:0] be;

    status_reg dut (
        .clk(clk), .reset_n(reset_n),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_co(alu_co),
        .alu_sub(alu_sub), .en_nz(en_nz), .en_c(en_c), .en_v(en_v),
        .bit_mode(bit_mode), .flag_op(flag_op), .ld_p(ld_p), .db(db),
        .irq_take(irq_take), .brk_in(brk_in), .cond(cond),
        .p_push(p_push), .c_out(c_out), .d_out(d_out), .i_out(i_out),
        .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    // Reference model of the P register
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mp <= 8'h04;
        end else begin
            nx = mp;
            if (ld_p) begin
                nx = db & 8'hCF;
            end else begin
                if (en_nz) begin
                    nx[1] = (alu_f == 8'h00);
                    nx[7] = bit_mode ? alu_b[7] : alu_f[7];
                end
                if (en_c) nx[0] = alu_co;
                if (en_v) begin
                    be = alu_sub ? ~alu_b : alu_b;
                    nx[6] = bit_mode ? alu_b[6]
                          : ((alu_a[7] == be[7]) && (alu_f[7] != alu_a[7]));
                end
                case (flag_op)
                    3'd1: nx[0] = 1'b0;
                    3'd2: nx[0] = 1'b1;
                    3'd3: nx[2] = 1'b0;
                    3'd4: nx[2] = 1'b1;
                    3'd5: nx[3] = 1'b0;
                    3'd6: nx[3] = 1'b1;
                    3'd7: nx[6] = 1'b0;
                    default: ;
                endcase
            end
            if (irq_take) nx[2] = 1'b1;
            mp <= nx;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the model
    task automatic compare_model();
        logic [7:0] exp_p;
        logic [7:0] fidx [4];
        logic       exp_br;
        fidx[0] = 8'd7; fidx[1] = 8'd6; fidx[2] = 8'd0; fidx[3] = 8'd1;
        exp_p  = mp | 8'h20 | {3'b000, brk_in, 4'b0000};
        exp_br = (mp[fidx[cond[2:1]]] == cond[0]);
        check("p_push", p_push, exp_p);
        check("c_out", {7'd0, c_out}, {7'd0, mp[0]});
        check("d_out", {7'd0, d_out}, {7'd0, mp[3]});
        check("i_out", {7'd0, i_out}, {7'd0, mp[2]});
        check("br_taken", {7'd0, br_taken}, {7'd0, exp_br});
    endtask

    task automatic idle();
        alu_a = 0; alu_b = 0; alu_f = 0; alu_co = 0; alu_sub = 0;
        en_nz = 0; en_c = 0; en_v = 0; bit_mode = 0; flag_op = 0;
        ld_p = 0; db = 0; irq_take = 0;
    endtask

    // One clock of the applied request, then check at the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
        idle();
    endtask

    initial begin
        idle();
        brk_in = 1'b1;
        cond = 3'd0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Make state non-reset, then pulse reset between edges
        flag_op = 3'd2; step();
        flag_op = 3'd6; step();
        check("sec_sed", p_push, 8'h3D);
        #2 reset_n = 1'b0;
        #1;
        check("rst_p_push", p_push, 8'h34);
        check("rst_c_out", {7'd0, c_out}, 8'h00);
        check("rst_i_out", {7'd0, i_out}, 8'h01);
        compare_model();
        #1 reset_n = 1'b1;

        // Signed add overflow
        alu_a = 8'h50; alu_b = 8'h50; alu_f = 8'hA0; alu_co = 0; alu_sub = 0;
        en_nz = 1; en_c = 1; en_v = 1;
        step();
        check("add_nvzc", p_push & 8'hC3, 8'hC0);
        cond = 3'd3; #1;
        check("add_bvs", {7'd0, br_taken}, 8'h01);

        // Compare equal
        alu_a = 8'h05; alu_b = 8'h05; alu_f = 8'h00; alu_co = 1; alu_sub = 1;
        en_nz = 1; en_c = 1; en_v = 1;
        step();
        check("sub_nvzc", p_push & 8'hC3, 8'h03);
        cond = 3'd7; #1;
        check("sub_beq", {7'd0, br_taken}, 8'h01);
        cond = 3'd4; #1;
        check("sub_bcc", {7'd0, br_taken}, 8'h00);

        // BIT leaves C alone
        alu_b = 8'hC0; alu_f = 8'h00; bit_mode = 1; en_nz = 1; en_v = 1;
        step();
        check("bit_nvzc", p_push & 8'hC3, 8'hC3);

        // Priority: CLC over en_c, IRQ over CLI
        flag_op = 3'd1; en_c = 1; alu_co = 1;
        step();
        check("clc_prio", {7'd0, c_out}, 8'h00);
        flag_op = 3'd3;
        step();
        check("cli", {7'd0, i_out}, 8'h00);
        flag_op = 3'd3; irq_take = 1;
        step();
        check("cli_irq", {7'd0, i_out}, 8'h01);

        // PLP ignores ALU update
        brk_in = 1; ld_p = 1; db = 8'hFF; en_nz = 1; alu_f = 8'h00;
        step();
        check("plp_ff", p_push, 8'hFF);
        brk_in = 0; #1;
        check("plp_ef", p_push, 8'hEF);
        ld_p = 1; db = 8'h00; irq_take = 1;
        step();
        check("plp_irq", p_push, 8'h24);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            alu_a    = 8'($urandom);
            alu_b    = 8'($urandom);
            alu_f    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            alu_co   = 1'($urandom);
            alu_sub  = 1'($urandom);
            en_nz    = 1'($urandom);
            en_c     = 1'($urandom);
            en_v     = 1'($urandom);
            bit_mode = ($urandom_range(0, 3) == 0);
            flag_op  = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'd0;
            ld_p     = ($urandom_range(0, 7) == 0);
            db       = 8'($urandom);
            irq_take = ($urandom_range(0, 7) == 0);
            brk_in   = 1'($urandom);
            cond     = 3'($urandom);
            @(posedge clk);
            @(negedge clk);
            compare_model();
            if ($urandom_range(0, 99) == 0) begin
                #2 reset_n = 1'b0;
                #1 compare_model();
                #1 reset_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
